// File: rtl/fan_pwm_gen.sv
// fan_pwm_gen: turns the signed PID controller output into a glitch-free fan PWM.
// The target duty is floored to MIN_DUTY, kick-started at full speed when the fan
// leaves standstill, and slew-limited once running. All updates land on period
// boundaries so the waveform never produces runt pulses.
//
// Ports:
//   clk_i          clock
//   rstn_i         asynchronous active-low reset
//   en_i           synchronous enable; low holds the block idle
//   PID_val_i      signed controller output (ADC_BITWIDTH+1 bits)
//   PID_valid_i    one-cycle strobe that latches PID_val_i
//   pwm_o          registered PWM waveform
//   period_strb_o  one-cycle pulse in the first clock of every period
//   duty_o         duty currently applied
//   kick_o         high while the kick-start is in progress
module fan_pwm_gen #(
    parameter int unsigned ADC_BITWIDTH = 8,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned MIN_DUTY     = 32,
    parameter int unsigned SLEW_STEP    = 16,
    parameter int unsigned KICK_PERIODS = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      en_i,
    input  logic signed [ADC_BITWIDTH:0] PID_val_i,
    input  logic                      PID_valid_i,
    output logic                      pwm_o,
    output logic                      period_strb_o,
    output logic [ADC_BITWIDTH-1:0]   duty_o,
    output logic                      kick_o
);
    localparam int unsigned N   = ADC_BITWIDTH;
    localparam int unsigned NW1 = N + 1;
    localparam int unsigned PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned KW  = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;

    localparam logic [N-1:0]   DUTY_FULL = {N{1'b1}};
    localparam logic [N-1:0]   CNT_LAST  = DUTY_FULL - N'(1);
    localparam logic [N-1:0]   MIN_D     = N'(MIN_DUTY);
    localparam logic [N:0]     SLEW      = NW1'(SLEW_STEP);
    localparam logic [PW-1:0]  PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic [KW-1:0]  KICK_INIT = KW'((KICK_PERIODS > 0) ? KICK_PERIODS - 1 : 0);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_KICK = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  duty_q, duty_d;
    logic [N-1:0]  target_q, target_d;
    logic [N-1:0]  cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [KW-1:0] kcnt_q, kcnt_d;
    logic          pwm_q, pwm_d;
    logic          strb_q, strb_d;
    logic          kick_q, kick_d;

    logic          tick;
    logic          boundary;
    logic [N-1:0]  ct;
    logic [N:0]    diff;
    logic [N:0]    step;
    logic [N:0]    duty_up;
    logic [N:0]    duty_dn;

    // Target latch: non-positive controller output means "fan off".
    always_comb begin
        target_d = target_q;
        if (PID_valid_i) begin
            target_d = (PID_val_i[N] || (PID_val_i == '0)) ? '0 : PID_val_i[N-1:0];
        end
    end

    // Any nonzero target is raised to the minimum duty the fan can sustain.
    assign ct = (target_q == '0) ? '0 : ((target_q < MIN_D) ? MIN_D : target_q);

    // Prescaler and PWM counter; both parked at zero while disabled.
    assign tick     = (pre_q == PRE_LAST);
    assign boundary = en_i && tick && (cnt_q == CNT_LAST);

    always_comb begin
        pre_d = '0;
        cnt_d = '0;
        if (en_i) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            cnt_d = cnt_q;
            if (tick) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + N'(1);
            end
        end
    end

    // Slew arithmetic in N+1 bits so the step never wraps.
    always_comb begin
        diff    = (ct > duty_q) ? ({1'b0, ct} - {1'b0, duty_q}) : ({1'b0, duty_q} - {1'b0, ct});
        step    = (diff < SLEW) ? diff : SLEW;
        duty_up = {1'b0, duty_q} + step;
        duty_dn = {1'b0, duty_q} - step;
    end

    // State machine: only evaluated at period boundaries.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        kcnt_d  = kcnt_q;
        if (!en_i) begin
            state_d = ST_OFF;
            duty_d  = '0;
            kcnt_d  = '0;
        end else if (boundary) begin
            case (state_q)
                ST_OFF: begin
                    if (ct != '0) begin
                        if (KICK_PERIODS > 0) begin
                            state_d = ST_KICK;
                            duty_d  = DUTY_FULL;
                            kcnt_d  = KICK_INIT;
                        end else begin
                            state_d = ST_RUN;
                            duty_d  = ct;
                        end
                    end
                end
                ST_KICK: begin
                    if (ct == '0) begin
                        state_d = ST_OFF;
                        duty_d  = '0;
                        kcnt_d  = '0;
                    end else if (kcnt_q != '0) begin
                        kcnt_d = kcnt_q - KW'(1);
                    end else begin
                        state_d = ST_RUN;
                        duty_d  = ct;
                    end
                end
                ST_RUN: begin
                    if (ct == '0) begin
                        // Stop is immediate; the slew limiter is bypassed.
                        state_d = ST_OFF;
                        duty_d  = '0;
                    end else if (ct > duty_q) begin
                        duty_d = N'(duty_up);
                    end else begin
                        duty_d = N'(duty_dn);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    duty_d  = '0;
                    kcnt_d  = '0;
                end
            endcase
        end
    end

    // Output registers: pwm aligned with the count it will be shown against.
    always_comb begin
        pwm_d  = en_i && (cnt_d < duty_d);
        strb_d = boundary;
        kick_d = (state_d == ST_KICK);
    end

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_OFF;
            duty_q   <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            pre_q    <= '0;
            kcnt_q   <= '0;
            pwm_q    <= 1'b0;
            strb_q   <= 1'b0;
            kick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            kcnt_q   <= kcnt_d;
            pwm_q    <= pwm_d;
            strb_q   <= strb_d;
            kick_q   <= kick_d;
        end
    end

    assign pwm_o         = pwm_q;
    assign period_strb_o = strb_q;
    assign duty_o        = duty_q;
    assign kick_o        = kick_q;

endmodule

// File: tb/tb_fan_pwm_gen.sv
// tb_fan_pwm_gen: directed scenarios plus a randomized phase, all checked every
// cycle against a period-position model, with literal expectations per scenario.
module tb_fan_pwm_gen;
    localparam int N    = 8;
    localparam int NV   = N + 1;
    localparam int CD   = 2;
    localparam int MIN  = 32;
    localparam int SLEW = 16;
    localparam int KP   = 2;
    localparam int FULL = (1 << N) - 1;
    localparam int P    = FULL * CD;

    localparam int M_OFF = 0, M_KICK = 1, M_RUN = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic en = 1'b0;
    logic valid = 1'b0;
    logic signed [N:0] pid_val = '0;
    logic pwm, strb, kick;
    logic [N-1:0] duty;

    int checks = 0;
    int errors = 0;

    // Model: position within the period, plus state/duty/target as plain ints.
    int m_tgt = 0, m_pos = 0, m_state = M_OFF, m_duty = 0, m_kleft = 0;
    int m_pwm = 0, m_strb = 0;

    fan_pwm_gen #(
        .ADC_BITWIDTH(N),
        .CLK_DIV(CD),
        .MIN_DUTY(MIN),
        .SLEW_STEP(SLEW),
        .KICK_PERIODS(KP)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .en_i(en),
        .PID_val_i(pid_val),
        .PID_valid_i(valid),
        .pwm_o(pwm),
        .period_strb_o(strb),
        .duty_o(duty),
        .kick_o(kick)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_target(input int t);
        if (t == 0) return 0;
        return (t < MIN) ? MIN : t;
    endfunction

    // What happens when a period ends, from the state/target rules alone.
    task automatic model_boundary(input int c);
        if (m_state == M_OFF) begin
            if (c > 0) begin
                if (KP > 0) begin
                    m_state = M_KICK; m_duty = FULL; m_kleft = KP;
                end else begin
                    m_state = M_RUN; m_duty = c;
                end
            end
        end else if (m_state == M_KICK) begin
            if (c == 0) begin
                m_state = M_OFF; m_duty = 0; m_kleft = 0;
            end else begin
                m_kleft--;
                if (m_kleft == 0) begin
                    m_state = M_RUN; m_duty = c;
                end
            end
        end else begin
            if (c == 0) begin
                m_state = M_OFF; m_duty = 0;
            end else if (c > m_duty) begin
                m_duty = (m_duty + SLEW > c) ? c : m_duty + SLEW;
            end else begin
                m_duty = (m_duty - SLEW < c) ? c : m_duty - SLEW;
            end
        end
    endtask

    task automatic model_step();
        int v;
        int old_ct;
        if (!rstn) begin
            m_tgt = 0; m_pos = 0; m_state = M_OFF; m_duty = 0; m_kleft = 0;
            m_pwm = 0; m_strb = 0;
            return;
        end
        old_ct = clamp_target(m_tgt);
        if (valid) begin
            v = pid_val;
            m_tgt = (v <= 0) ? 0 : v;
        end
        if (!en) begin
            m_pos = 0; m_state = M_OFF; m_duty = 0; m_kleft = 0;
            m_pwm = 0; m_strb = 0;
        end else begin
            if (m_pos == P - 1) begin
                model_boundary(old_ct);
                m_pos  = 0;
                m_strb = 1;
            end else begin
                m_pos  = m_pos + 1;
                m_strb = 0;
            end
            m_pwm = (m_pos < m_duty * CD) ? 1 : 0;
        end
    endtask

    // Cycle-by-cycle compare against the model.
    always @(posedge clk) begin
        #1;
        model_step();
        check("cyc_pwm", pwm, m_pwm);
        check("cyc_strb", strb, m_strb);
        check("cyc_duty", duty, m_duty);
        check("cyc_kick", kick, (m_state == M_KICK) ? 1 : 0);
    end

    task automatic pulse(input int v);
        @(negedge clk);
        valid   = 1'b1;
        pid_val = NV'(v);
        fork
            begin
                @(negedge clk);
                valid = 1'b0;
            end
        join_none
    endtask

    task automatic first_strobe_latency(input string name);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!strb && n < P + 20);
        check(name, n, P);
    endtask

    // Waits for the next strobe, then gathers one full period.
    task automatic measure_period(output int d, output int k, output int hi);
        int n = 0;
        d = -1; k = -1; hi = -1;
        do begin
            @(posedge clk); #1; n++;
        end while (!strb && n < P + 30);
        check("strobe_seen", strb, 1);
        if (!strb) return;
        d = duty; k = kick; hi = pwm;
        repeat (P - 1) begin
            @(posedge clk); #1;
            hi += pwm;
        end
    endtask

    task automatic expect_period(input string name, input int ed, input int ek, input int ehi);
        int d, k, hi;
        measure_period(d, k, hi);
        check({name, "_duty"}, d, ed);
        check({name, "_kick"}, k, ek);
        check({name, "_high"}, hi, ehi);
    endtask

    initial begin
        int slew_exp[6];
        int n;
        int off_left;
        slew_exp = '{84, 68, 52, 36, 32, 32};

        // Reset, then enable: first strobe one full period later.
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        en   = 1'b1;
        check("reset_duty", duty, 0);
        first_strobe_latency("first_strobe_clocks");

        // Kick-start from OFF.
        pulse(100);
        expect_period("kick1", 255, 1, 510);
        expect_period("kick2", 255, 1, 510);
        expect_period("run100", 100, 0, 200);

        // Slew down toward the floor.
        repeat (5) @(negedge clk);
        pulse(10);
        for (int i = 0; i < 6; i++) begin
            expect_period($sformatf("slew%0d", i), slew_exp[i], 0, slew_exp[i] * CD);
        end

        // Ramp to 200, then a negative value stops at once.
        repeat (5) @(negedge clk);
        pulse(200);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (duty != 8'd200 && n < 16 * P);
        check("reach_200", duty, 200);
        repeat (5) @(negedge clk);
        pulse(-50);
        expect_period("stop", 0, 0, 0);
        expect_period("stay_off", 0, 0, 0);

        // Valid landing exactly on a boundary takes effect one period later.
        pulse(100);
        expect_period("coincide_old", 0, 0, 0);
        expect_period("coincide_new", 255, 1, 510);

        // Drop enable during the kick; re-enable redoes the kick in full.
        repeat (7) @(negedge clk);
        check("pwm_before_drop", pwm, 1);
        en = 1'b0;
        @(posedge clk); #1;
        check("drop_pwm", pwm, 0);
        check("drop_duty", duty, 0);
        check("drop_kick", kick, 0);
        repeat (20) @(negedge clk);
        en = 1'b1;
        expect_period("rekick1", 255, 1, 510);
        expect_period("rekick2", 255, 1, 510);
        expect_period("rerun100", 100, 0, 200);

        // Asynchronous reset mid-pulse.
        repeat (20) @(negedge clk);
        check("pwm_before_reset", pwm, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_pwm", pwm, 0);
        check("rst_duty", duty, 0);
        check("rst_kick", kick, 0);
        check("rst_strb", strb, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        first_strobe_latency("post_reset_strobe_clocks");

        // Randomized phase: sparse PID updates and short enable dropouts.
        off_left = 0;
        for (int c = 0; c < 9000; c++) begin
            @(negedge clk);
            if (off_left > 0) begin
                off_left--;
                en = 1'b0;
            end else begin
                en = 1'b1;
                if ($urandom_range(0, 2999) == 0) off_left = $urandom_range(1, 60);
            end
            if ($urandom_range(0, 299) == 0) begin
                valid = 1'b1;
                if ($urandom_range(0, 3) == 0) pid_val = NV'(-int'($urandom_range(0, 256)));
                else pid_val = NV'($urandom_range(1, 255));
            end else begin
                valid = 1'b0;
            end
        end
        @(negedge clk);
        valid = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
